// File: rtl/bcd_mod_counter_if.sv
// Control and result bundle for bcd_mod_counter.
// The dir signal exists only when BCDCNT_DOWN_EN is defined.
interface bcd_mod_counter_if #(
  parameter int DIGITS = 2
) ();
  logic                  key;
  logic                  tick;
  logic                  clr;
  logic                  load;
  logic [4*DIGITS-1:0]   load_val;
`ifdef BCDCNT_DOWN_EN
  logic                  dir;
`endif
  logic [4*DIGITS-1:0]   out;
  logic                  en_out;
  logic                  at_max;

  modport master (
`ifdef BCDCNT_DOWN_EN
    output dir,
`endif
    output key, tick, clr, load, load_val,
    input  out, en_out, at_max
  );

  modport slave (
`ifdef BCDCNT_DOWN_EN
    input  dir,
`endif
    input  key, tick, clr, load, load_val,
    output out, en_out, at_max
  );
endinterface

// File: rtl/bcd_mod_counter.sv
// Cascadable multi-digit BCD modulo counter with load, clear and carry pulse.
// Define BCDCNT_DOWN_EN to add the dir input and down-count/borrow logic.
module bcd_mod_counter #(
  parameter int DIGITS  = 2,
  parameter int TOP_MOD = 6,
  parameter int WRAP_AT = 0
) (
  input  logic              clk,
  input  logic              rst,
  bcd_mod_counter_if.slave  bus
);

  localparam int W = 4 * DIGITS;

  function automatic int pow10(input int n);
    int r;
    r = 1;
    for (int i = 0; i < n; i++) r = r * 10;
    return r;
  endfunction

  function automatic logic [W-1:0] to_bcd(input int v);
    logic [W-1:0] r;
    int           t;
    r = '0;
    t = v;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t           = t / 10;
    end
    return r;
  endfunction

  localparam int           NAT_MOD = TOP_MOD * pow10(DIGITS - 1);
  localparam int           MOD     = (WRAP_AT != 0) ? WRAP_AT : NAT_MOD;
  localparam logic [W-1:0] MAX_BCD = to_bcd(MOD - 1);
  localparam logic [3:0]   TOP_MAX = 4'(TOP_MOD - 1);

  // With every digit valid, BCD ordering matches numeric ordering, so one
  // vector compare against MAX_BCD enforces the full-value limit.
  function automatic logic load_ok(input logic [W-1:0] v);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (v[4*i +: 4] > 4'd9) ok = 1'b0;
      else ok = ok;
    end
    if (v[W-1 -: 4] > TOP_MAX) ok = 1'b0;
    else if (v > MAX_BCD) ok = 1'b0;
    else ok = ok;
    return ok;
  endfunction

  function automatic logic [W-1:0] bcd_incr(input logic [W-1:0] v);
    logic [W-1:0] r;
    logic         carry;
    r     = v;
    carry = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (carry && (r[4*i +: 4] == 4'd9)) begin
        r[4*i +: 4] = 4'd0;
      end else if (carry) begin
        r[4*i +: 4] = r[4*i +: 4] + 4'd1;
        carry       = 1'b0;
      end else begin
        carry = 1'b0;
      end
    end
    return r;
  endfunction

`ifdef BCDCNT_DOWN_EN
  function automatic logic [W-1:0] bcd_decr(input logic [W-1:0] v);
    logic [W-1:0] r;
    logic         borrow;
    r      = v;
    borrow = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (borrow && (r[4*i +: 4] == 4'd0)) begin
        r[4*i +: 4] = (i == DIGITS - 1) ? TOP_MAX : 4'd9;
      end else if (borrow) begin
        r[4*i +: 4] = r[4*i +: 4] - 4'd1;
        borrow      = 1'b0;
      end else begin
        borrow = 1'b0;
      end
    end
    return r;
  endfunction
`endif

  logic [W-1:0] out_r;
  logic         en_r;
  logic [W-1:0] next_out_s;
  logic         next_en_s;

  // Next count and carry pulse: key gates everything, then clr > load > tick.
  always_comb begin
    next_out_s = out_r;
    next_en_s  = 1'b0;
    if (!bus.key) begin
      next_out_s = out_r;
    end else if (bus.clr) begin
      next_out_s = '0;
    end else if (bus.load) begin
      next_out_s = load_ok(bus.load_val) ? bus.load_val : '0;
    end else if (bus.tick) begin
`ifdef BCDCNT_DOWN_EN
      if (bus.dir) begin
        if (out_r == '0) begin
          next_out_s = MAX_BCD;
          next_en_s  = 1'b1;
        end else begin
          next_out_s = bcd_decr(out_r);
        end
      end else
`endif
      if (out_r == MAX_BCD) begin
        next_out_s = '0;
        next_en_s  = 1'b1;
      end else begin
        next_out_s = bcd_incr(out_r);
      end
    end else begin
      next_out_s = out_r;
    end
  end

  // Count and carry registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_r <= '0;
      en_r  <= 1'b0;
    end else begin
      out_r <= next_out_s;
      en_r  <= next_en_s;
    end
  end

  assign bus.out    = out_r;
  assign bus.en_out = en_r;
  assign bus.at_max = (out_r == MAX_BCD);

endmodule

// File: tb/tb_bcd_mod_counter.sv
// Scoreboard bench for bcd_mod_counter: a mod-60 and a mod-24 instance.
// Down-count steps run only when BCDCNT_DOWN_EN is defined.
module tb_bcd_mod_counter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  bcd_mod_counter_if #(.DIGITS(2)) b60 ();
  bcd_mod_counter_if #(.DIGITS(2)) b24 ();

  bcd_mod_counter #(.DIGITS(2), .TOP_MOD(6), .WRAP_AT(0)) u60 (
    .clk (clk),
    .rst (rst),
    .bus (b60)
  );

  bcd_mod_counter #(.DIGITS(2), .TOP_MOD(3), .WRAP_AT(24)) u24 (
    .clk (clk),
    .rst (rst),
    .bus (b24)
  );

  typedef struct {
    bit         sel;
    string      tag;
    logic [7:0] o;
    logic       e;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   passed = 0;
  int   failed = 0;

  function automatic logic [7:0] to_bcd8(input int n);
    logic [7:0] r;
    r[7:4] = 4'(n / 10);
    r[3:0] = 4'(n % 10);
    return r;
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input bit sel, input string tag, input logic [7:0] o, input logic e);
    exp_t x;
    x.sel = sel;
    x.tag = tag;
    x.o   = o;
    x.e   = e;
    q.push_back(x);
  endtask

  task automatic cycle();
    exp_t x;
    @(posedge clk);
    @(negedge clk);
    while (q.size() > 0) begin
      x = q.pop_front();
      if (x.sel == 1'b0) begin
        chk({x.tag, ".out"}, b60.out, x.o);
        chk({x.tag, ".en"}, {7'd0, b60.en_out}, {7'd0, x.e});
        chk({x.tag, ".max"}, {7'd0, b60.at_max}, {7'd0, (x.o == 8'h59)});
      end else begin
        chk({x.tag, ".out"}, b24.out, x.o);
        chk({x.tag, ".en"}, {7'd0, b24.en_out}, {7'd0, x.e});
        chk({x.tag, ".max"}, {7'd0, b24.at_max}, {7'd0, (x.o == 8'h23)});
      end
    end
  endtask

  task automatic drv60(input logic k, input logic t, input logic c, input logic l, input logic [7:0] v);
    b60.key      = k;
    b60.tick     = t;
    b60.clr      = c;
    b60.load     = l;
    b60.load_val = v;
  endtask

  task automatic drv24(input logic k, input logic t, input logic c, input logic l, input logic [7:0] v);
    b24.key      = k;
    b24.tick     = t;
    b24.clr      = c;
    b24.load     = l;
    b24.load_val = v;
  endtask

  initial begin
    int cnt;
    int nxt;
    rst = 1'b0;
    drv60(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    drv24(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
`ifdef BCDCNT_DOWN_EN
    b60.dir = 1'b0;
    b24.dir = 1'b0;
`endif
    repeat (3) @(negedge clk);
    chk("rst60.out", b60.out, 8'h00);
    chk("rst60.en", {7'd0, b60.en_out}, 8'h00);
    chk("rst24.out", b24.out, 8'h00);
    chk("rst24.max", {7'd0, b24.at_max}, 8'h00);
    rst = 1'b1;

    // 61 continuous ticks against an integer reference count
    drv60(1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
    drv24(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    cnt = 0;
    for (int i = 0; i < 61; i++) begin
      nxt = (cnt + 1) % 60;
      push(1'b0, "run", to_bcd8(nxt), (cnt == 59));
      cycle();
      cnt = nxt;
    end

    // hours instance: wrap at 23, illegal loads
    drv60(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    drv24(1'b1, 1'b0, 1'b0, 1'b1, 8'h23);
    push(1'b0, "hold60", 8'h01, 1'b0);
    push(1'b1, "h_load23", 8'h23, 1'b0);
    cycle();
    drv24(1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
    push(1'b1, "h_wrap", 8'h00, 1'b1);
    cycle();
    drv24(1'b1, 1'b0, 1'b0, 1'b1, 8'h25);
    push(1'b1, "h_ill25", 8'h00, 1'b0);
    cycle();
    drv24(1'b1, 1'b0, 1'b0, 1'b1, 8'h19);
    push(1'b1, "h_load19", 8'h19, 1'b0);
    cycle();
    drv24(1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
    push(1'b1, "h_19to20", 8'h20, 1'b0);
    cycle();
    drv24(1'b1, 1'b0, 1'b0, 1'b1, 8'h1A);
    push(1'b1, "h_ill1A", 8'h00, 1'b0);
    cycle();
    drv24(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);

    // load beats a simultaneous tick
    drv60(1'b1, 1'b1, 1'b0, 1'b1, 8'h39);
    push(1'b0, "ld39_tick", 8'h39, 1'b0);
    cycle();
    drv60(1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
    push(1'b0, "39to40", 8'h40, 1'b0);
    cycle();

    // clr beats load and tick; key=0 holds
    drv60(1'b1, 1'b1, 1'b1, 1'b1, 8'h45);
    push(1'b0, "clr_all", 8'h00, 1'b0);
    cycle();
    drv60(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 5; i++) begin
      push(1'b0, "keyoff", 8'h00, 1'b0);
      cycle();
    end
    drv60(1'b1, 1'b0, 1'b0, 1'b1, 8'h59);
    push(1'b0, "ld59", 8'h59, 1'b0);
    cycle();
    drv60(1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
    push(1'b0, "wrap60", 8'h00, 1'b1);
    cycle();
    drv60(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    push(1'b0, "keyoff_en", 8'h00, 1'b0);
    cycle();
    drv60(1'b1, 1'b0, 1'b0, 1'b1, 8'h60);
    push(1'b0, "ill60", 8'h00, 1'b0);
    cycle();

`ifdef BCDCNT_DOWN_EN
    b60.dir = 1'b1;
    drv60(1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
    push(1'b0, "dn_00to59", 8'h59, 1'b1);
    cycle();
    push(1'b0, "dn_59to58", 8'h58, 1'b0);
    cycle();
    drv60(1'b1, 1'b0, 1'b0, 1'b1, 8'h10);
    push(1'b0, "dn_ld10", 8'h10, 1'b0);
    cycle();
    drv60(1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
    push(1'b0, "dn_10to09", 8'h09, 1'b0);
    cycle();
    b24.dir = 1'b1;
    drv60(1'b1, 1'b0, 1'b1, 1'b0, 8'h00);
    drv24(1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
    push(1'b0, "dn_clr", 8'h00, 1'b0);
    push(1'b1, "h_dn_00to23", 8'h23, 1'b1);
    cycle();
    drv24(1'b1, 1'b0, 1'b0, 1'b1, 8'h20);
    push(1'b1, "h_ld20", 8'h20, 1'b0);
    cycle();
    drv24(1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
    push(1'b1, "h_dn_20to19", 8'h19, 1'b0);
    cycle();
    b60.dir = 1'b0;
    b24.dir = 1'b0;
    drv24(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
`endif

    // asynchronous reset mid-cycle
    drv60(1'b1, 1'b0, 1'b0, 1'b1, 8'h37);
    push(1'b0, "ld37", 8'h37, 1'b0);
    cycle();
    drv60(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    #2 rst = 1'b0;
    #1;
    chk("arst.out", b60.out, 8'h00);
    chk("arst.en", {7'd0, b60.en_out}, 8'h00);
    @(negedge clk);
    rst = 1'b1;
    drv60(1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
    push(1'b0, "resume", 8'h01, 1'b0);
    cycle();

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/bcd_mod_counter.md
Name: bcd_mod_counter

Overview:
Parametrised, cascadable multi-digit BCD modulo counter for the digital clock datapath. It generalises the single mod-10 digit counter to N digits, with a configurable modulus on the most significant digit. One instance covers seconds/minutes (mod 60) or hours (mod 24 via DIGITS=2, TOP_MOD=3 plus an explicit wrap value). It adds synchronous load for time-set, synchronous clear, a count request input and an optional down-count mode. en_out is the one-cycle carry that drives the next stage's tick.

Parameters:
DIGITS, 2, number of BCD digits; legal range 1..4.
TOP_MOD, 6, modulus of the most significant digit; legal range 2..10.
WRAP_AT, 0, full-count wrap value as an integer; 0 selects the natural modulus TOP_MOD*10^(DIGITS-1). Hours use 24.

Ports:
clk  in  1  clock; all state changes on the rising edge.
rst  in  1  asynchronous, active-low reset.
key  in  1  global run enable; when 0, all state is held.
tick  in  1  count request, one step per cycle while high.
clr  in  1  synchronous clear to zero.
load  in  1  synchronous load strobe.
load_val  in  4*DIGITS  BCD value to load; digit 0 in bits [3:0].
dir  in  1  count direction, 0 = up, 1 = down; present only with BCDCNT_DOWN_EN.
out  out  4*DIGITS  current BCD count, registered.
en_out  out  1  registered wrap/borrow pulse.
at_max  out  1  combinational; high when out equals the maximum count (M-1).

Behaviour:
- M = WRAP_AT if nonzero, else TOP_MOD*10^(DIGITS-1). Count range 0..M-1.
- rst low: out=0 and en_out=0 immediately, regardless of key or clk.
- Reset is not gated by key.
- key=0: out held; en_out forced to 0 on the next edge.
- key=1 priority per edge: clr > load > tick > hold.
- clr: out=0, en_out=0.
- load: each digit copied from load_val. Any digit >9, top digit >=TOP_MOD, or full value >=M makes the whole count load 0. en_out=0.
- tick, up direction:
  - Digit 0 increments 9->0.
  - Digit i advances only when all lower digits are 9.
  - At M-1 the next count is 0 and en_out=1.
- tick, down direction:
  - Digit i decrements when all lower digits are 0; each digit borrows 0->9, except the top digit, which borrows to TOP_MOD-1.
  - At 0 the next count is M-1 and en_out=1.
- en_out is high only for the single cycle after a wrap edge, then returns to 0 unless the next edge wraps again. M=1 is illegal.
- Latency: out reflects tick/load/clr one edge later.
- WRAP_AT must satisfy 2 <= WRAP_AT <= natural modulus. If WRAP_AT is below the natural modulus, the up-wrap triggers at WRAP_AT-1 regardless of digit boundaries.
- Simultaneous clr and load: clr wins. Simultaneous load and tick: the loaded value is used and the tick is discarded.
- Reset asserted mid-count: outputs clear asynchronously; counting resumes from 0 after the first edge with rst high.
- at_max is valid for any out value, including just after load.

Optional Feature:
BCDCNT_DOWN_EN:
- Defined: the dir port exists and down-count/borrow behaves as specified.
- Undefined: dir is absent, the counter is up-only, and down-count logic is not synthesised.

Test Plan:
- DIGITS=2, TOP_MOD=6: hold rst low for 3 cycles, then tick continuously for 61 cycles -> out steps 00,01..59,00,01. en_out=1 for exactly one cycle, after the 59->00 edge.
- WRAP_AT=24, TOP_MOD=3: load 23, tick once -> out=00, en_out=1. Load 0x25 -> out=00 (illegal), en_out=0.
- Mod-60: load 0x39 and assert tick in the same cycle -> out=39. Next tick -> out=40, en_out=0.
- Mod-60: clr, load 0x45 and tick all high in one cycle -> out=00. Then key=0 with tick high for 5 cycles -> out stays 00, en_out=0.
- Mod-60, macro defined: dir=1 from out=00, tick -> out=59, en_out=1. Tick again -> out=58, en_out=0. Load 0x10 then tick -> out=09.
- Mod-60: drive rst low asynchronously mid-cycle at out=37 -> out=00 and en_out=0 before the next clk edge.
